bcd_field_reg: RTL

Parametrised two-digit packed-BCD time/date field register for the RTC front panel. Holds one field (seconds, minutes, hours, day, month, year) with a configurable legal range. The field is loaded from the RTC read path when not being edited, and stepped up/down by the panel buttons when being edited, with press-and-hold auto-repeat. It flags user edits so the RTC controller knows which fields to write back.

---
 rtl/bcd_pkg.sv | 64 ++++++
 rtl/bcd_step.sv | 21 ++
 rtl/bcd_field_reg.sv | 120 ++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the RTC front-panel BCD field registers:
// FSM encoding, button direction codes, BCD digit helpers and per-field ranges.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } fsm_state_t;

    // DIR_HOLD marks "direction unknown since reset": a held button must be released first.
    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DN   = 2'd2,
        DIR_HOLD = 2'd3
    } dir_t;

    localparam logic [7:0] SEC_MIN   = 8'h00;
    localparam logic [7:0] SEC_MAX   = 8'h59;
    localparam logic [7:0] MIN_MIN   = 8'h00;
    localparam logic [7:0] MIN_MAX   = 8'h59;
    localparam logic [7:0] HOUR_MIN  = 8'h00;
    localparam logic [7:0] HOUR_MAX  = 8'h23;
    localparam logic [7:0] DAY_MIN   = 8'h01;
    localparam logic [7:0] DAY_MAX   = 8'h31;
    localparam logic [7:0] MONTH_MIN = 8'h01;
    localparam logic [7:0] MONTH_MAX = 8'h12;
    localparam logic [7:0] YEAR_MIN  = 8'h00;
    localparam logic [7:0] YEAR_MAX  = 8'h99;

    function automatic logic bcd_valid(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = v[7:4];
        lo = v[3:0];
        if (lo >= 4'd9) begin
            lo = 4'd0;
            hi = (hi >= 4'd9) ? 4'd0 : hi + 4'd1;
        end else begin
            lo = lo + 4'd1;
        end
        return {hi, lo};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = v[7:4];
        lo = v[3:0];
        if (lo == 4'd0) begin
            lo = 4'd9;
            hi = (hi == 4'd0) ? 4'd9 : hi - 4'd1;
        end else begin
            lo = lo - 4'd1;
        end
        return {hi, lo};
    endfunction

endpackage

// File: rtl/bcd_step.sv
// Combinational one-step BCD up/down counter with wrap inside [min_val, max_val].
module bcd_step
    import bcd_pkg::*;
(
    input  logic [7:0] value,
    input  logic       up,
    input  logic [7:0] min_val,
    input  logic [7:0] max_val,
    output logic [7:0] next_val
);

    always_comb begin
        next_val = value;
        if (up) begin
            next_val = (value == max_val) ? min_val : bcd_inc(value);
        end else begin
            next_val = (value == min_val) ? max_val : bcd_dec(value);
        end
    end

endmodule

// File: rtl/bcd_field_reg.sv
// Two-digit packed-BCD field register: RTC load path, button stepping with
// press-and-hold auto-repeat, and a sticky edited flag for write-back.
module bcd_field_reg
    import bcd_pkg::*;
#(
    parameter logic [7:0] MIN_VAL       = 8'h00,
    parameter logic [7:0] MAX_VAL       = 8'h59,
    parameter int         HOLD_CYCLES   = 1048575,
    parameter int         REPEAT_CYCLES = 262143,
    parameter int         CNT_W         = 20
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       UP,
    input  logic       DOWN,
    input  logic       Modificando,
    input  logic       Actualizar,
    input  logic [7:0] DATA_in,
    output logic [7:0] DATA_out,
    output logic       Modificado,
    input  logic       Limpiar,
    output logic       Dato_invalido
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    fsm_state_t       state;
    logic [CNT_W-1:0] timer;
    dir_t             dir_p0;
    dir_t             dir_p1;
    logic             released;
    logic             new_press;
    logic             load;
    logic             load_ok;
    logic             do_step;
    logic             step_up;
    logic [7:0]       step_val;

    always_comb begin
        dir_p0 = DIR_NONE;
        if (UP && !DOWN) begin
            dir_p0 = DIR_UP;
        end else if (DOWN && !UP) begin
            dir_p0 = DIR_DN;
        end
    end

    // A direction change without release counts as a fresh press.
    assign released  = (dir_p0 == DIR_NONE);
    assign new_press = !released && (dir_p0 != dir_p1) && (dir_p1 != DIR_HOLD);
    assign step_up   = (dir_p0 == DIR_UP);

    assign load    = !Modificando && Actualizar;
    assign load_ok = bcd_valid(DATA_in) && (DATA_in >= MIN_VAL) && (DATA_in <= MAX_VAL);

    always_comb begin
        do_step = 1'b0;
        if (Modificando) begin
            if (new_press) begin
                do_step = 1'b1;
            end else if (!released) begin
                do_step = ((state == ST_DELAY)  && (timer == HOLD_LAST)) ||
                          ((state == ST_REPEAT) && (timer == REP_LAST));
            end
        end
    end

    bcd_step u_step (
        .value    (DATA_out),
        .up       (step_up),
        .min_val  (MIN_VAL),
        .max_val  (MAX_VAL),
        .next_val (step_val)
    );

    // Stage p1: previous button direction, FSM, timer and field value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            DATA_out      <= MIN_VAL;
            Modificado    <= 1'b0;
            Dato_invalido <= 1'b0;
            state         <= ST_IDLE;
            timer         <= '0;
            dir_p1        <= DIR_HOLD;
        end else begin
            dir_p1        <= dir_p0;
            Dato_invalido <= 1'b0;
            if (load) begin
                DATA_out      <= load_ok ? DATA_in : MIN_VAL;
                Dato_invalido <= !load_ok;
                Modificado    <= 1'b0;
                state         <= ST_IDLE;
                timer         <= '0;
            end else if (!Modificando) begin
                state <= ST_IDLE;
                timer <= '0;
                if (Limpiar) begin
                    Modificado <= 1'b0;
                end
            end else if (do_step) begin
                DATA_out   <= step_val;
                Modificado <= 1'b1;
                timer      <= '0;
                state      <= new_press ? ST_DELAY : ST_REPEAT;
            end else begin
                if (Limpiar) begin
                    Modificado <= 1'b0;
                end
                if (released) begin
                    state <= ST_IDLE;
                    timer <= '0;
                end else if (state != ST_IDLE) begin
                    timer <= timer + CNT_W'(1);
                end
            end
        end
    end

endmodule
